// File: rtl/score_pkg.sv
// Shared types and constants for the HUD score/lives text writer.
package score_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONVERT  = 3'd1,
    WR_DIG   = 3'd2,
    WR_LIVES = 3'd3,
    FINISH   = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_BLANK    = 8'h00;
  localparam int         SCORE_MAX      = 9999;
  localparam int         LIVES_MAX      = 9;
  localparam int         SCORE_ADDR_DEF = 7;
  localparam int         LIVES_ADDR_DEF = 32;

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = res[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift/add-3 step per clock, 4 BCD digits out.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [15:0]      bcd,
  output logic             valid
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shift_r;
  logic [15:0]      bcd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             valid_r;
  logic [BIN_W+15:0] load_s;
  logic [BIN_W+15:0] step_s;

  // The start edge already performs the first shift (adjusting an all-zero BCD is a no-op).
  always_comb begin
    load_s = {16'd0, bin} << 1;
    step_s = {dd_adjust(bcd_r), shift_r} << 1;
  end

  // Step counter and shift register; valid pulses once the last step has landed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_r <= '0;
      bcd_r   <= 16'd0;
      cnt_r   <= '0;
      valid_r <= 1'b0;
    end else if (start) begin
      {bcd_r, shift_r} <= load_s;
      cnt_r            <= CNT_W'(1);
      valid_r          <= 1'b0;
    end else if (cnt_r != '0) begin
      {bcd_r, shift_r} <= step_s;
      if (cnt_r == CNT_W'(BIN_W - 1)) begin
        cnt_r   <= '0;
        valid_r <= 1'b1;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bcd   = bcd_r;
  assign valid = valid_r;

endmodule

// File: rtl/score_text_writer.sv
// HUD text RAM writer: clamps score/lives, converts score to BCD, writes 5 ASCII slots.
// Build option SCORE_LEAD_BLANK_EN: leading-zero score digits are written as blanks.
module score_text_writer
  import score_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int DIGITS     = 4,
  parameter int ADDR_W     = 8,
  parameter int SCORE_ADDR = SCORE_ADDR_DEF,
  parameter int LIVES_ADDR = LIVES_ADDR_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [3:0]         lives_in,
  input  logic               update,
  output logic               busy,
  output logic               done,
  output logic               we,
  output logic [ADDR_W-1:0]  write_address,
  output logic [7:0]         data_out
);

  state_e             state_r;
  logic               pending_r;
  logic [2:0]         idx_r;
  logic [3:0]         lives_r;
  logic [SCORE_W-1:0] score_clamp_s;
  logic [3:0]         lives_clamp_s;
  logic               rerun_s;
  logic               start_s;
  logic [15:0]        bcd_s;
  logic               bcd_valid_s;
  logic [2:0]         wr_idx_s;
  logic [3:0]         digit_s;
  logic               lead_blank_s;
  logic [7:0]         digit_byte_s;

  // Input clamping and the conversion start condition (fresh request or queued rerun).
  always_comb begin
    score_clamp_s = (score_in > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_in;
    lives_clamp_s = (lives_in > 4'(LIVES_MAX)) ? 4'(LIVES_MAX) : lives_in;
    rerun_s       = pending_r || update;
    start_s       = ((state_r == IDLE) && update) || ((state_r == FINISH) && rerun_s);
    wr_idx_s      = (state_r == CONVERT) ? 3'd0 : idx_r;
  end

  bin2bcd_seq #(.BIN_W(SCORE_W)) u_bin2bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start_s),
    .bin     (score_clamp_s),
    .bcd     (bcd_s),
    .valid   (bcd_valid_s)
  );

  // Select the digit being written (MSD first) and form its text byte.
  always_comb begin
    case (wr_idx_s)
      3'd0:    digit_s = bcd_s[15:12];
      3'd1:    digit_s = bcd_s[11:8];
      3'd2:    digit_s = bcd_s[7:4];
      default: digit_s = bcd_s[3:0];
    endcase
`ifdef SCORE_LEAD_BLANK_EN
    case (wr_idx_s)
      3'd0:    lead_blank_s = (bcd_s[15:12] == 4'd0);
      3'd1:    lead_blank_s = (bcd_s[15:8] == 8'd0);
      3'd2:    lead_blank_s = (bcd_s[15:4] == 12'd0);
      default: lead_blank_s = 1'b0;
    endcase
`else
    lead_blank_s = 1'b0;
`endif
    digit_byte_s = lead_blank_s ? ASCII_BLANK : (ASCII_ZERO + {4'd0, digit_s});
  end

  // Control FSM with registered write-port outputs; address/data hold when we is low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= IDLE;
      pending_r     <= 1'b0;
      idx_r         <= 3'd0;
      lives_r       <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      we            <= 1'b0;
      write_address <= '0;
      data_out      <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          we   <= 1'b0;
          done <= 1'b0;
          if (update) begin
            lives_r   <= lives_clamp_s;
            pending_r <= 1'b0;
            busy      <= 1'b1;
            state_r   <= CONVERT;
          end else begin
            busy <= 1'b0;
          end
        end
        CONVERT: begin
          if (update) pending_r <= 1'b1;
          else        pending_r <= pending_r;
          if (bcd_valid_s) begin
            we            <= 1'b1;
            write_address <= ADDR_W'(SCORE_ADDR);
            data_out      <= digit_byte_s;
            idx_r         <= 3'd1;
            state_r       <= WR_DIG;
          end else begin
            we <= 1'b0;
          end
        end
        WR_DIG: begin
          if (update) pending_r <= 1'b1;
          else        pending_r <= pending_r;
          we <= 1'b1;
          if (idx_r == 3'(DIGITS)) begin
            write_address <= ADDR_W'(LIVES_ADDR);
            data_out      <= ASCII_ZERO + {4'd0, lives_r};
            state_r       <= WR_LIVES;
          end else begin
            write_address <= ADDR_W'(SCORE_ADDR) + ADDR_W'(idx_r);
            data_out      <= digit_byte_s;
            idx_r         <= idx_r + 3'd1;
          end
        end
        WR_LIVES: begin
          // busy stays up through FINISH only when a rerun is already queued.
          we        <= 1'b0;
          done      <= 1'b1;
          pending_r <= rerun_s;
          busy      <= rerun_s;
          state_r   <= FINISH;
        end
        FINISH: begin
          we        <= 1'b0;
          done      <= 1'b0;
          pending_r <= 1'b0;
          if (rerun_s) begin
            lives_r <= lives_clamp_s;
            busy    <= 1'b1;
            state_r <= CONVERT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          we      <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_writer.sv
// Directed self-checking bench for score_text_writer (honours SCORE_LEAD_BLANK_EN).
module tb_score_text_writer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [13:0] score_in;
  logic [3:0]  lives_in;
  logic        update;
  logic        busy;
  logic        done;
  logic        we;
  logic [7:0]  write_address;
  logic [7:0]  data_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  score_text_writer dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .score_in      (score_in),
    .lives_in      (lives_in),
    .update        (update),
    .busy          (busy),
    .done          (done),
    .we            (we),
    .write_address (write_address),
    .data_out      (data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected text byte for score digit k (0 = most significant).
  function automatic logic [7:0] exp_dig(input int s, input int k);
    int c;
    int d;
    c = (s > 9999) ? 9999 : s;
    case (k)
      0:       d = c / 1000;
      1:       d = (c / 100) % 10;
      2:       d = (c / 10) % 10;
      default: d = c % 10;
    endcase
`ifdef SCORE_LEAD_BLANK_EN
    if ((k == 0 && c < 1000) || (k == 1 && c < 100) || (k == 2 && c < 10)) return 8'h00;
`endif
    return 8'(32'h30 + d);
  endfunction

  function automatic logic [7:0] exp_lives(input int l);
    return 8'(32'h30 + ((l > 9) ? 9 : l));
  endfunction

  // Accepting edge E0.
  task automatic accept(input int s, input int l, input bit hold);
    score_in = 14'(s);
    lives_in = 4'(l);
    update   = 1'b1;
    tick();
    if (!hold) update = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_we", 32'(we), 32'd0);
  endtask

  // Edges E1..E19 of one run; optionally pulses update (with new score s2) at edge pulse_at.
  task automatic expect_seq(input int s, input int l, input bit rerun, input int pulse_at,
                            input int s2);
    bit saw_we;
    bit lost_busy;
    saw_we    = 1'b0;
    lost_busy = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (we) saw_we = 1'b1;
      if (!busy) lost_busy = 1'b1;
      if (pulse_at != 0 && e == pulse_at - 1) begin
        score_in = 14'(s2);
        update   = 1'b1;
      end else if (pulse_at != 0 && e == pulse_at) begin
        update = 1'b0;
      end
    end
    chk("convert_no_we", 32'(saw_we), 32'd0);
    chk("convert_busy", 32'(lost_busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("dig%0d_we", k), 32'(we), 32'd1);
      chk($sformatf("dig%0d_addr", k), 32'(write_address), 32'(7 + k));
      chk($sformatf("dig%0d_data", k), 32'(data_out), 32'(exp_dig(s, k)));
    end
    tick();
    chk("lives_we", 32'(we), 32'd1);
    chk("lives_addr", 32'(write_address), 32'd32);
    chk("lives_data", 32'(data_out), 32'(exp_lives(l)));
    tick();
    chk("finish_we", 32'(we), 32'd0);
    chk("finish_done", 32'(done), 32'd1);
    chk("finish_busy", 32'(busy), 32'(rerun));
  endtask

  // Edge after FINISH: done must be a single-cycle pulse.
  task automatic finish_chk(input bit busy_exp);
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'(busy_exp));
  endtask

  initial begin
    bit saw_we;

    Reset_n  = 1'b0;
    score_in = 14'd0;
    lives_in = 4'd0;
    update   = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(write_address), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // 1: basic conversion
    accept(1234, 2, 1'b0);
    expect_seq(1234, 2, 1'b0, 0, 0);
    finish_chk(1'b0);
    saw_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (we || busy) saw_we = 1'b1;
    end
    chk("idle_quiet", 32'(saw_we), 32'd0);
    chk("idle_addr_hold", 32'(write_address), 32'd32);
    chk("idle_data_hold", 32'(data_out), 32'h32);

    // 2: clamping
    accept(10000, 12, 1'b0);
    expect_seq(10000, 12, 1'b0, 0, 0);
    finish_chk(1'b0);

    // 3: request while busy collapses into one rerun
    accept(5, 1, 1'b0);
    expect_seq(5, 1, 1'b1, 5, 77);
    finish_chk(1'b1);
    expect_seq(77, 1, 1'b0, 0, 0);
    finish_chk(1'b0);

    // 4: async reset in the middle of the digit writes
    accept(1234, 2, 1'b0);
    for (int e = 1; e <= 16; e++) tick();
    chk("mid_addr", 32'(write_address), 32'd9);
    chk("mid_we", 32'(we), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_we", 32'(we), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_addr", 32'(write_address), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    saw_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (we || busy || done) saw_we = 1'b1;
    end
    chk("post_reset_quiet", 32'(saw_we), 32'd0);

    // 5: leading zeros (blank or ASCII depending on build)
    accept(0, 0, 1'b0);
    expect_seq(0, 0, 1'b0, 0, 0);
    finish_chk(1'b0);
    accept(42, 7, 1'b0);
    expect_seq(42, 7, 1'b0, 0, 0);
    finish_chk(1'b0);

    // 6: update held high -> back-to-back runs
    accept(300, 3, 1'b1);
    expect_seq(300, 3, 1'b1, 0, 0);
    finish_chk(1'b1);
    expect_seq(300, 3, 1'b1, 0, 0);
    update = 1'b0;
    finish_chk(1'b1);
    expect_seq(300, 3, 1'b0, 0, 0);
    finish_chk(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
